// File: rtl/apb_pixel_loader.sv
// apb_pixel_loader: APB slave front end of the watermarking core.
// Holds the configuration register file. In LOAD it turns in-order pixel
// writes into one-cycle new_pixel strobes. Image_Done is raised once all
// 2*ImgSize^2 pixels of the image have been delivered.
module apb_pixel_loader #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int PIX_WIDTH    = 8,
    parameter int CNT_WIDTH    = 21,
    // Lowest accepted ImgSize. A smaller value permits short images in simulation.
    parameter int IMG_SIZE_MIN = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  Start,
    output logic [7:0]            White_Pixel,
    output logic [9:0]            ImgSize,
    output logic [9:0]            WmSize,
    output logic [6:0]            M,
    output logic [4:0]            Bthr,
    output logic [6:0]            Amin,
    output logic [6:0]            Amax,
    output logic [5:0]            Bmin,
    output logic [5:0]            Bmax,
    output logic                  new_pixel,
    output logic [PIX_WIDTH-1:0]  Pixel_Data,
    output logic                  Pixel_Sel,
    output logic                  Image_Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int NUM_CFG = 10;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   total_q, total_d;
    logic [CNT_WIDTH-1:0]   half_q, half_d;   // ImgSize^2: first watermark index

    logic                   start_q, start_d;
    logic [7:0]             white_q, white_d;
    logic [9:0]             img_size_q, img_size_d;
    logic [9:0]             wm_size_q, wm_size_d;
    logic [6:0]             m_q, m_d;
    logic [4:0]             bthr_q, bthr_d;
    logic [6:0]             amin_q, amin_d;
    logic [6:0]             amax_q, amax_d;
    logic [5:0]             bmin_q, bmin_d;
    logic [5:0]             bmax_q, bmax_d;

    logic                   new_pixel_q, new_pixel_d;
    logic [PIX_WIDTH-1:0]   pixel_data_q, pixel_data_d;
    logic                   pixel_sel_q, pixel_sel_d;

    logic                   access;
    logic                   wr_access;
    logic                   is_cfg;
    logic [3:0]             cfg_idx;
    logic [ADDR_WIDTH-1:0]  pix_addr;
    logic                   pix_data_ok;
    logic                   pix_ok;
    logic [19:0]            img_sq;
    logic                   slv_err;
    logic [DATA_WIDTH-1:0]  rd_data;

    logic [DATA_WIDTH-1:0]  range_lo [NUM_CFG];
    logic [DATA_WIDTH-1:0]  range_hi [NUM_CFG];
    logic [15:0]            range_ok;

    // Transfer decode. Reset masks the bus so writes during reset have no effect.
    assign access    = PSEL && PENABLE && !rst;
    assign wr_access = access && PWRITE;
    assign is_cfg    = (PADDR < ADDR_WIDTH'(NUM_CFG));
    assign cfg_idx   = PADDR[3:0];
    assign pix_addr  = ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(NUM_CFG);
    assign pix_data_ok = (PWDATA[DATA_WIDTH-1:PIX_WIDTH] == '0);
    // Accept only the next pixel in sequence, and only while the image is incomplete.
    assign pix_ok    = (state_q == S_LOAD) && (PADDR == pix_addr)
                       && (cnt_q < total_q) && pix_data_ok;
    assign img_sq    = {10'd0, img_size_q} * {10'd0, img_size_q};

    // Accepted range for each configuration register. Amin/Bmin are bounded by
    // the registered Amax/Bmax, not by a write in the same cycle.
    always_comb begin
        range_lo[0] = DATA_WIDTH'(0);            range_hi[0] = DATA_WIDTH'(1);
        range_lo[1] = DATA_WIDTH'(1);            range_hi[1] = DATA_WIDTH'(255);
        range_lo[2] = DATA_WIDTH'(IMG_SIZE_MIN); range_hi[2] = DATA_WIDTH'(720);
        range_lo[3] = DATA_WIDTH'(200);          range_hi[3] = DATA_WIDTH'(720);
        range_lo[4] = DATA_WIDTH'(1);            range_hi[4] = DATA_WIDTH'(72);
        range_lo[5] = DATA_WIDTH'(1);            range_hi[5] = DATA_WIDTH'(20);
        range_lo[6] = DATA_WIDTH'(80);           range_hi[6] = DATA_WIDTH'(amax_q);
        range_lo[7] = DATA_WIDTH'(90);           range_hi[7] = DATA_WIDTH'(99);
        range_lo[8] = DATA_WIDTH'(20);           range_hi[8] = DATA_WIDTH'(bmax_q);
        range_lo[9] = DATA_WIDTH'(30);           range_hi[9] = DATA_WIDTH'(40);
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_range
            if (gi < NUM_CFG) begin : g_cfg
                assign range_ok[gi] = (PWDATA >= range_lo[gi]) && (PWDATA <= range_hi[gi]);
            end else begin : g_none
                assign range_ok[gi] = 1'b0;
            end
        end
    endgenerate

    // Next-state logic: register writes, FSM transitions and pixel acceptance.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        total_d      = total_q;
        half_d       = half_q;
        start_d      = start_q;
        white_d      = white_q;
        img_size_d   = img_size_q;
        wm_size_d    = wm_size_q;
        m_d          = m_q;
        bthr_d       = bthr_q;
        amin_d       = amin_q;
        amax_d       = amax_q;
        bmin_d       = bmin_q;
        bmax_d       = bmax_q;
        new_pixel_d  = 1'b0;
        pixel_data_d = pixel_data_q;
        pixel_sel_d  = pixel_sel_q;
        slv_err      = 1'b0;

        if (wr_access) begin
            if (is_cfg) begin
                // While loading only Start may be written; the rest stay frozen.
                if (!range_ok[cfg_idx] || (state_q == S_LOAD && cfg_idx != 4'd0)) begin
                    slv_err = 1'b1;
                end else begin
                    case (cfg_idx)
                        4'd0: begin
                            start_d = PWDATA[0];
                            if (PWDATA[0]) begin
                                // A new load latches the image size at entry.
                                if (state_q != S_LOAD) begin
                                    state_d = S_LOAD;
                                    cnt_d   = '0;
                                    half_d  = CNT_WIDTH'(img_sq);
                                    total_d = CNT_WIDTH'({img_sq, 1'b0});
                                end
                            end else begin
                                state_d = S_IDLE;
                                cnt_d   = '0;
                            end
                        end
                        4'd1:    white_d    = PWDATA[7:0];
                        4'd2:    img_size_d = PWDATA[9:0];
                        4'd3:    wm_size_d  = PWDATA[9:0];
                        4'd4:    m_d        = PWDATA[6:0];
                        4'd5:    bthr_d     = PWDATA[4:0];
                        4'd6:    amin_d     = PWDATA[6:0];
                        4'd7:    amax_d     = PWDATA[6:0];
                        4'd8:    bmin_d     = PWDATA[5:0];
                        4'd9:    bmax_d     = PWDATA[5:0];
                        default: slv_err    = 1'b1;
                    endcase
                end
            end else if (pix_ok) begin
                // Host pixels come first, then watermark pixels.
                new_pixel_d  = 1'b1;
                pixel_data_d = PWDATA[PIX_WIDTH-1:0];
                pixel_sel_d  = (cnt_q >= half_q);
                cnt_d        = cnt_q + CNT_WIDTH'(1);
                if (cnt_q + CNT_WIDTH'(1) == total_q) begin
                    state_d = S_DONE;
                end
            end else begin
                slv_err = 1'b1;
            end
        end
    end

    // Register readback, zero-extended; unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        if (access && !PWRITE && is_cfg) begin
            case (cfg_idx)
                4'd0:    rd_data = DATA_WIDTH'(start_q);
                4'd1:    rd_data = DATA_WIDTH'(white_q);
                4'd2:    rd_data = DATA_WIDTH'(img_size_q);
                4'd3:    rd_data = DATA_WIDTH'(wm_size_q);
                4'd4:    rd_data = DATA_WIDTH'(m_q);
                4'd5:    rd_data = DATA_WIDTH'(bthr_q);
                4'd6:    rd_data = DATA_WIDTH'(amin_q);
                4'd7:    rd_data = DATA_WIDTH'(amax_q);
                4'd8:    rd_data = DATA_WIDTH'(bmin_q);
                4'd9:    rd_data = DATA_WIDTH'(bmax_q);
                default: rd_data = '0;
            endcase
        end
    end

    // State and register file update, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            total_q      <= '0;
            half_q       <= '0;
            start_q      <= 1'b0;
            white_q      <= '0;
            img_size_q   <= '0;
            wm_size_q    <= '0;
            m_q          <= '0;
            bthr_q       <= '0;
            amin_q       <= '0;
            amax_q       <= '0;
            bmin_q       <= '0;
            bmax_q       <= '0;
            new_pixel_q  <= 1'b0;
            pixel_data_q <= '0;
            pixel_sel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            total_q      <= total_d;
            half_q       <= half_d;
            start_q      <= start_d;
            white_q      <= white_d;
            img_size_q   <= img_size_d;
            wm_size_q    <= wm_size_d;
            m_q          <= m_d;
            bthr_q       <= bthr_d;
            amin_q       <= amin_d;
            amax_q       <= amax_d;
            bmin_q       <= bmin_d;
            bmax_q       <= bmax_d;
            new_pixel_q  <= new_pixel_d;
            pixel_data_q <= pixel_data_d;
            pixel_sel_q  <= pixel_sel_d;
        end
    end

    assign PRDATA      = rd_data;
    assign PREADY      = 1'b1;
    assign PSLVERR     = slv_err;
    assign Start       = start_q;
    assign White_Pixel = white_q;
    assign ImgSize     = img_size_q;
    assign WmSize      = wm_size_q;
    assign M           = m_q;
    assign Bthr        = bthr_q;
    assign Amin        = amin_q;
    assign Amax        = amax_q;
    assign Bmin        = bmin_q;
    assign Bmax        = bmax_q;
    assign new_pixel   = new_pixel_q;
    assign Pixel_Data  = pixel_data_q;
    assign Pixel_Sel   = pixel_sel_q;
    assign Image_Done  = (state_q == S_DONE);

endmodule

// File: tb/tb_apb_pixel_loader.sv
// Scoreboard bench for apb_pixel_loader. A 4x4 image (32 pixels) keeps loads short.
module tb_apb_pixel_loader;

    localparam int IMG = 4;
    localparam int HALF = IMG * IMG;
    localparam int TOTAL = 2 * HALF;

    logic        clk;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        Start;
    logic [7:0]  White_Pixel;
    logic [9:0]  ImgSize, WmSize;
    logic [6:0]  M;
    logic [4:0]  Bthr;
    logic [6:0]  Amin, Amax;
    logic [5:0]  Bmin, Bmax;
    logic        new_pixel;
    logic [7:0]  Pixel_Data;
    logic        Pixel_Sel;
    logic        Image_Done;

    apb_pixel_loader #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PIX_WIDTH(8), .CNT_WIDTH(21),
        .IMG_SIZE_MIN(IMG)
    ) dut (
        .clk(clk), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .Start(Start), .White_Pixel(White_Pixel), .ImgSize(ImgSize), .WmSize(WmSize),
        .M(M), .Bthr(Bthr), .Amin(Amin), .Amax(Amax), .Bmin(Bmin), .Bmax(Bmax),
        .new_pixel(new_pixel), .Pixel_Data(Pixel_Data), .Pixel_Sel(Pixel_Sel),
        .Image_Done(Image_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        string       name;
    } apb_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       sel;
        logic       done;
    } pix_exp_t;

    apb_exp_t apb_q[$];
    pix_exp_t pix_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    function automatic logic [7:0] pix(input int k, input int pass);
        return 8'((k * 37 + pass * 11 + 5) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Monitor: compares every access phase and every pixel strobe against the queues.
    always @(negedge clk) begin
        apb_exp_t ae;
        pix_exp_t pe;
        if (mon_en) begin
            if (PSEL && PENABLE) begin
                n_checks++;
                if (apb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL apb_unexpected: addr %0d with no expectation", PADDR);
                end else begin
                    ae = apb_q.pop_front();
                    if (PSLVERR !== ae.err) begin
                        n_fail++;
                        $display("FAIL %s pslverr: got %b expected %b", ae.name, PSLVERR, ae.err);
                    end else if (ae.chk_rd && PRDATA !== ae.rd) begin
                        n_fail++;
                        $display("FAIL %s prdata: got %0d expected %0d", ae.name, PRDATA, ae.rd);
                    end else begin
                        $display("apb  %s addr=%0d wr=%b err=%b rdata=%0d", ae.name, PADDR, PWRITE, PSLVERR, PRDATA);
                    end
                end
            end
            if (new_pixel) begin
                n_checks++;
                if (pix_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pix_unexpected: data %0d sel %b", Pixel_Data, Pixel_Sel);
                end else begin
                    pe = pix_q.pop_front();
                    if (Pixel_Data !== pe.data || Pixel_Sel !== pe.sel || Image_Done !== pe.done) begin
                        n_fail++;
                        $display("FAIL pixel: got data=%0d sel=%b done=%b expected data=%0d sel=%b done=%b",
                                 Pixel_Data, Pixel_Sel, Image_Done, pe.data, pe.sel, pe.done);
                    end else begin
                        $display("pix  data=%0d sel=%b done=%b", Pixel_Data, Pixel_Sel, Image_Done);
                    end
                end
            end
        end
    end

    task automatic apb(input bit wr, input int addr, input int data,
                       input bit exp_err, input bit chk_rd, input int exp_rd, input string name);
        apb_exp_t e;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        e.err = exp_err; e.chk_rd = chk_rd; e.rd = exp_rd; e.name = name;
        apb_q.push_back(e);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input int addr, input int data, input bit exp_err, input string name);
        apb(1'b1, addr, data, exp_err, 1'b0, 0, name);
    endtask

    task automatic rd(input int addr, input int exp_rd, input string name);
        apb(1'b0, addr, 0, 1'b0, 1'b1, exp_rd, name);
    endtask

    task automatic pix_write(input int k, input int pass);
        pix_exp_t p;
        p.data = pix(k, pass);
        p.sel  = (k >= HALF);
        p.done = (k == TOTAL - 1);
        pix_q.push_back(p);
        wr(10 + k, int'(pix(k, pass)), 1'b0, "pixel");
    endtask

    task automatic load_all(input int pass);
        for (int k = 0; k < TOTAL; k++) pix_write(k, pass);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        // Reset with random bus traffic
        repeat (3) begin
            @(posedge clk); #1;
            PSEL = 1'($urandom); PENABLE = 1'($urandom); PWRITE = 1'($urandom);
            PADDR = $urandom_range(0, 20); PWDATA = $urandom_range(0, 300);
        end
        @(posedge clk); #1;
        rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        chk("reset new_pixel", new_pixel, 0);
        chk("reset Image_Done", Image_Done, 0);
        chk("reset PREADY", PREADY, 1);
        chk("reset Start", Start, 0);
        chk("reset Pixel_Data", Pixel_Data, 0);
        mon_en = 1'b1;
        for (int a = 0; a < 10; a++) rd(a, 0, "reset_read");
        rd(10, 0, "read_unmapped");

        // Configuration range checks
        wr(7, 95, 1'b0, "Amax=95");
        wr(6, 96, 1'b1, "Amin=96>Amax");
        rd(6, 0, "Amin_unchanged");
        wr(6, 85, 1'b0, "Amin=85");
        rd(6, 85, "Amin_read");
        wr(6, 79, 1'b1, "Amin=79");
        wr(7, 100, 1'b1, "Amax=100");
        wr(7, 89, 1'b1, "Amax=89");
        wr(2, IMG - 1, 1'b1, "ImgSize_low");
        wr(2, 721, 1'b1, "ImgSize_high");
        wr(2, IMG, 1'b0, "ImgSize_ok");
        wr(3, 720, 1'b0, "WmSize=720");
        wr(3, 199, 1'b1, "WmSize=199");
        wr(1, 0, 1'b1, "White=0");
        wr(1, 255, 1'b0, "White=255");
        wr(4, 73, 1'b1, "M=73");
        wr(4, 72, 1'b0, "M=72");
        wr(5, 21, 1'b1, "Bthr=21");
        wr(5, 5, 1'b0, "Bthr=5");
        wr(9, 35, 1'b0, "Bmax=35");
        wr(8, 36, 1'b1, "Bmin=36>Bmax");
        wr(8, 20, 1'b0, "Bmin=20");
        wr(0, 2, 1'b1, "Start=2");
        wr(10, 1, 1'b1, "pixel_in_idle");
        rd(2, IMG, "ImgSize_read");
        rd(1, 255, "White_read");
        chk("Bmin output", Bmin, 20);

        // Partial load with out-of-order and locked-config errors
        wr(0, 1, 1'b0, "Start=1");
        for (int k = 0; k < 5; k++) pix_write(k, 0);
        wr(16, 1, 1'b1, "pixel_skip");
        wr(4, 10, 1'b1, "M_in_load");
        rd(4, 72, "M_unchanged");
        wr(15, 256, 1'b1, "pixel_data_256");
        pix_write(5, 0);
        pix_write(6, 0);
        wr(10 + TOTAL, 1, 1'b1, "pixel_past_end");
        wr(0, 0, 1'b0, "Start=0_abort");
        chk("abort Image_Done", Image_Done, 0);
        wr(17, 1, 1'b1, "pixel_after_abort");
        wr(10, 1, 1'b1, "pixel10_after_abort");

        // Full load from address 10
        wr(0, 1, 1'b0, "Start=1_restart");
        load_all(1);
        chk("done Image_Done", Image_Done, 1);
        wr(10 + TOTAL, 1, 1'b1, "pixel_in_done");
        wr(10, 1, 1'b1, "pixel10_in_done");
        wr(4, 5, 1'b0, "M_in_done");
        rd(4, 5, "M_read_done");
        wr(0, 0, 1'b0, "Start=0_from_done");
        chk("idle Image_Done", Image_Done, 0);
        rd(0, 0, "Start_read");

        // Second full load, then restart from DONE
        wr(0, 1, 1'b0, "Start=1_second");
        load_all(2);
        chk("done2 Image_Done", Image_Done, 1);
        wr(0, 1, 1'b0, "Start=1_from_done");
        chk("restart Image_Done", Image_Done, 0);
        pix_write(0, 3);
        pix_write(1, 3);

        // Reset during an accepted-looking pixel access
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12; PWDATA = 32'h55;
        @(posedge clk); #1;
        PENABLE = 1'b1; rst = 1'b1; mon_en = 1'b0;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("rst new_pixel", new_pixel, 0);
        chk("rst Image_Done", Image_Done, 0);
        chk("rst Pixel_Data", Pixel_Data, 0);
        chk("rst Start", Start, 0);
        chk("rst M", M, 0);
        chk("rst ImgSize", ImgSize, 0);
        chk("rst Amax", Amax, 0);
        rst = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;
        chk("post_rst new_pixel", new_pixel, 0);
        rd(0, 0, "Start_after_rst");
        rd(2, 0, "ImgSize_after_rst");

        // Zero-size image: no pixel address is valid
        wr(0, 1, 1'b0, "Start=1_size0");
        wr(10, 1, 1'b1, "pixel_size0");

        repeat (3) @(posedge clk);
        #1;
        chk("pix_queue_empty", pix_q.size(), 0);
        chk("apb_queue_empty", apb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
